// File: rtl/fpu_pkg.sv
// Shared FPU types: register/data widths and the writeback entry bundle.
// Imported by the writeback buffer and its match sub-module.
package fpu_pkg;

  localparam int FP_REG_W  = 5;
  localparam int FP_DATA_W = 32;

  typedef struct packed {
    logic [FP_REG_W-1:0]  rd;
    logic [FP_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/fpu_wb_match.sv
// Youngest-match search over the pending writeback entries.
// Instantiated only when FPU_WB_BYPASS_EN is defined.
module fpu_wb_match
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  wb_entry_t             ent_i [DEPTH],
  input  logic [PW-1:0]         rptr_i,
  input  logic [CW-1:0]         count_i,
  input  logic [FP_REG_W-1:0]   lookup_rd_i,
  output logic                  hit_o,
  output logic [FP_DATA_W-1:0]  data_o
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = rptr_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_i + PW'(k);
      if (CW'(k) < count_i &&
          lookup_rd_i != '0 &&
          ent_i[idx].rd == lookup_rd_i) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/fpu_wb_buffer.sv
// FPU result writeback FIFO in front of the FP register-file write port.
// Define FPU_WB_BYPASS_EN to enable the pending-write lookup port.
module fpu_wb_buffer
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 res_valid,
  input  logic [FP_REG_W-1:0]  res_rd,
  input  logic [FP_DATA_W-1:0] res_data,
  output logic                 res_ready,
  input  logic                 drain_hold,
  input  logic                 flush,
  output logic [FP_REG_W-1:0]  mem_rd,
  output logic [FP_DATA_W-1:0] mem_write_data,
  output logic                 mem_write_enable,
  output logic [CW-1:0]        count,
  input  logic [FP_REG_W-1:0]  lookup_rd,
  output logic                 lookup_hit,
  output logic [FP_DATA_W-1:0] lookup_data
);

  wb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, store, pop;

  assign res_ready = (count_q < CW'(DEPTH)) && !flush;
  assign push      = res_valid && res_ready;
  // x0 results complete the handshake but never occupy a slot.
  assign store     = push && (res_rd != '0);

  assign mem_write_enable = (count_q != '0) && !drain_hold && !flush;
  assign pop              = mem_write_enable;
  assign count            = count_q;

  always_comb begin
    mem_rd         = '0;
    mem_write_data = '0;
    if (count_q != '0) begin
      mem_rd         = ent_q[rptr_q].rd;
      mem_write_data = ent_q[rptr_q].data;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (store) wptr_d = wptr_q + PW'(1);
      if (pop)   rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(store) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity comes from count.
  always_ff @(posedge clock) begin
    if (store && !flush) begin
      ent_q[wptr_q] <= '{rd: res_rd, data: res_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (count_q <= CW'(DEPTH))
        else $error("occupancy above DEPTH");
      assert (!(push && count_q == CW'(DEPTH)))
        else $error("push accepted while full");
    end
  end

`ifdef FPU_WB_BYPASS_EN
  fpu_wb_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .ent_i      (ent_q),
    .rptr_i     (rptr_q),
    .count_i    (count_q),
    .lookup_rd_i(lookup_rd),
    .hit_o      (lookup_hit),
    .data_o     (lookup_data)
  );
`else
  logic unused_lookup;
  assign unused_lookup = ^lookup_rd;
  assign lookup_hit    = 1'b0;
  assign lookup_data   = '0;
`endif

endmodule
